up_sequencer: RTL and testbench
===============================

// Module: up_sequencer
// PURPOSE
//  Fetch/execute sequencer and control decoder for the 4-bit uP datapath (PC, program ROM, fetch reg, ALU, accu, RAM).
//  Alternates FETCH/EXECUTE phases, decodes instr + flags into the datapath enables and supports run/halt/single-step.
//  Also counts retired instructions.
//  Sits between the fetch register (instr, c_flag, z_flag) and the datapath enable/select inputs.
// PARAMETERS
//  RET_W  8  width of retired-instruction counter (wraps modulo 2**RET_W)
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset
//  run       in   1      1 = free-run, 0 = halted/step mode (level)
//  step      in   1      1-cycle pulse; executes exactly one instruction while run=0
//  instr     in   4      opcode from fetch register, valid during EXECUTE
//  c_flag    in   1      carry flag (registered)
//  z_flag    in   1      zero flag (registered)
//  phase     out  1      0 = FETCH, 1 = EXECUTE
//  halted    out  1      1 while in HALT state
//  pc_en     out  1      PC increment
//  pc_load   out  1      PC loads {oprnd, program_byte} jump target
//  fetch_en  out  1      fetch register captures program_byte
//  accu_en   out  1      accumulator captures ALU result
//  flags_en  out  1      c/z flag register captures ALU flags
//  bus1_en   out  1      oprnd drives data_bus
//  bus2_en   out  1      ALU drives data_bus
//  in_en     out  1      pushbuttons drive data_bus
//  out_en    out  1      FF_out captures data_bus
//  ram_cs    out  1      RAM chip select
//  ram_we    out  1      RAM write (only with ram_cs)
//  alu_sel   out  3      000 pass A, 001 CMP(A-B), 010 pass B, 011 ADD, 100 NAND
//  retired   out  RET_W  instructions completed since reset
// BEHAVIOUR
//  States: HALT, FETCH, EXEC. reset low -> HALT async; all outputs 0, retired=0, phase=0, halted=1.
//  HALT: run=1 -> FETCH; run=0 & step=1 -> FETCH with step_pending=1; else stay.
//  FETCH (1 cycle): fetch_en=1, pc_en=1, phase=0; -> EXEC.
//  EXEC (1 cycle): phase=1, decode below; retired++ on exit; -> FETCH if run=1 & !step_pending else HALT (clear step_pending).
//  run falling mid-instruction: current instruction always completes; halts at next EXEC exit.
//  step while run=1 or while not in HALT: ignored. step & run rising same cycle in HALT: run wins, step_pending=0.
//  EXEC decode (all others 0); jumps take PC 12-bit target, pc_en=1 when not taken (skip address byte):
//   0000 JC   c ? pc_load : pc_en     0001 JNC  !c ? pc_load : pc_en
//   0010 CMPI bus1,alu 001,flags      0011 CMPM ram_cs,alu 001,flags
//   0100 LIT  bus1,alu 010,accu       0101 IN   in_en,alu 010,accu
//   0110 LD   ram_cs,alu 010,accu     0111 ST   ram_cs,ram_we,bus2,alu 000
//   1000 ADDI bus1,alu 011,accu,flags 1001 ADDM ram_cs,alu 011,accu,flags
//   1010 JMP  pc_load                 1011 OUT  bus2,alu 000,out_en
//   1100 NANDI bus1,alu 100,accu,flags 1101 NANDM ram_cs,alu 100,accu,flags
//   1110 JZ   z ? pc_load : pc_en     1111 JNZ  !z ? pc_load : pc_en
//  Bus exclusivity: at most one of bus1_en, bus2_en, in_en and (ram_cs & !ram_we) high in any cycle.
//  Outputs are Moore-decoded from state and registered instr/flags (no combinational path from step/run).
//  retired wraps 2**RET_W-1 -> 0 without flag.
// TESTING
//  reset low mid-EXEC of ADDI -> same cycle all enables 0, halted=1, retired=0; release, run=1 -> FETCH next edge.
//  run=1, instr=1000 -> phase toggles 0,1,0,1; during EXEC bus1_en=1, accu_en=1, flags_en=1, alu_sel=011.
//  instr=0000 with c=1 -> pc_load=1, pc_en=0; with c=0 -> pc_load=0, pc_en=1; repeat for JNC/JZ/JNZ.
//  run=0, single step pulse in HALT -> exactly FETCH, EXEC, HALT; retired +1; second step pulse -> +1 again.
//  run=1 for 2**RET_W+1 instructions -> retired wraps to 1; step pulses while running ignored.
//  All 16 opcodes x flag combos -> check bus-exclusivity assertion and ram_we only with instr=0111.

Source files
------------

// File: rtl/up_sequencer_if.sv
// Bus between the uP fetch register/datapath and the fetch/execute sequencer.
//   run, step       : run level and single-step pulse
//   instr, c_flag,
//   z_flag          : registered opcode and ALU flags from the fetch/flag registers
//   phase, halted   : 0 = FETCH / 1 = EXECUTE, and HALT state indicator
//   pc_en .. alu_sel: datapath enables and ALU operation select
//   retired         : retired-instruction count, RET_W bits, wraps
interface up_sequencer_if #(
  parameter int unsigned RET_W = 8
);
  logic             run;
  logic             step;
  logic [3:0]       instr;
  logic             c_flag;
  logic             z_flag;
  logic             phase;
  logic             halted;
  logic             pc_en;
  logic             pc_load;
  logic             fetch_en;
  logic             accu_en;
  logic             flags_en;
  logic             bus1_en;
  logic             bus2_en;
  logic             in_en;
  logic             out_en;
  logic             ram_cs;
  logic             ram_we;
  logic [2:0]       alu_sel;
  logic [RET_W-1:0] retired;

  modport master (
    output run, step, instr, c_flag, z_flag,
    input  phase, halted, pc_en, pc_load, fetch_en, accu_en, flags_en,
           bus1_en, bus2_en, in_en, out_en, ram_cs, ram_we, alu_sel, retired
  );

  modport slave (
    input  run, step, instr, c_flag, z_flag,
    output phase, halted, pc_en, pc_load, fetch_en, accu_en, flags_en,
           bus1_en, bus2_en, in_en, out_en, ram_cs, ram_we, alu_sel, retired
  );
endinterface

// File: rtl/up_sequencer.sv
// Fetch/execute sequencer and control decoder for the 4-bit uP datapath.
// Alternates FETCH and EXECUTE, decodes the opcode and flags into datapath
// enables, supports run/halt/single-step and counts retired instructions.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset (forces HALT, clears the counter)
//   bus   : up_sequencer_if.slave (run/step/instr/flags in, enables/retired out)
// The enables are decoded from the state register and the registered
// instr/flags only, so there is no combinational path from run or step.
module up_sequencer #(
  parameter int unsigned RET_W = 8
) (
  input logic           clk,
  input logic           reset,
  up_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_JC    = 4'b0000, OP_JNC   = 4'b0001, OP_CMPI = 4'b0010, OP_CMPM = 4'b0011,
    OP_LIT   = 4'b0100, OP_IN    = 4'b0101, OP_LD   = 4'b0110, OP_ST   = 4'b0111,
    OP_ADDI  = 4'b1000, OP_ADDM  = 4'b1001, OP_JMP  = 4'b1010, OP_OUT  = 4'b1011,
    OP_NANDI = 4'b1100, OP_NANDM = 4'b1101, OP_JZ   = 4'b1110, OP_JNZ  = 4'b1111
  } op_t;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_CMP    = 3'b001;
  localparam logic [2:0] ALU_PASS_B = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_NAND   = 3'b100;

  state_t           state_q, state_d;
  logic             step_pend_q, step_pend_d;
  logic [RET_W-1:0] retired_q;

  logic       phase, halted, pc_en, pc_load, fetch_en, accu_en, flags_en;
  logic       bus1_en, bus2_en, in_en, out_en, ram_cs, ram_we;
  logic [2:0] alu_sel;

  // State, step-pending flag and retired counter (wraps silently)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HALT;
      step_pend_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      if (state_q == S_EXEC) retired_q <= retired_q + RET_W'(1);
    end
  end

  // Next state and Moore decode of the datapath controls
  always_comb begin
    state_d     = state_q;
    step_pend_d = step_pend_q;
    phase       = 1'b0;
    halted      = 1'b0;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    fetch_en    = 1'b0;
    accu_en     = 1'b0;
    flags_en    = 1'b0;
    bus1_en     = 1'b0;
    bus2_en     = 1'b0;
    in_en       = 1'b0;
    out_en      = 1'b0;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    alu_sel     = ALU_PASS_A;

    unique case (state_q)
      S_HALT: begin
        halted = 1'b1;
        // run has priority over a simultaneous step pulse
        if (bus.run) begin
          state_d     = S_FETCH;
          step_pend_d = 1'b0;
        end else if (bus.step) begin
          state_d     = S_FETCH;
          step_pend_d = 1'b1;
        end
      end

      S_FETCH: begin
        fetch_en = 1'b1;
        pc_en    = 1'b1;
        state_d  = S_EXEC;
      end

      S_EXEC: begin
        phase       = 1'b1;
        step_pend_d = 1'b0;
        state_d     = (bus.run && !step_pend_q) ? S_FETCH : S_HALT;
        // Untaken jumps still advance the PC past the address byte
        unique case (op_t'(bus.instr))
          OP_JC:    begin pc_load = bus.c_flag;  pc_en = !bus.c_flag; end
          OP_JNC:   begin pc_load = !bus.c_flag; pc_en = bus.c_flag;  end
          OP_JZ:    begin pc_load = bus.z_flag;  pc_en = !bus.z_flag; end
          OP_JNZ:   begin pc_load = !bus.z_flag; pc_en = bus.z_flag;  end
          OP_JMP:   pc_load = 1'b1;
          OP_CMPI:  begin bus1_en = 1'b1; alu_sel = ALU_CMP; flags_en = 1'b1; end
          OP_CMPM:  begin ram_cs  = 1'b1; alu_sel = ALU_CMP; flags_en = 1'b1; end
          OP_LIT:   begin bus1_en = 1'b1; alu_sel = ALU_PASS_B; accu_en = 1'b1; end
          OP_IN:    begin in_en   = 1'b1; alu_sel = ALU_PASS_B; accu_en = 1'b1; end
          OP_LD:    begin ram_cs  = 1'b1; alu_sel = ALU_PASS_B; accu_en = 1'b1; end
          OP_ST:    begin ram_cs  = 1'b1; ram_we = 1'b1; bus2_en = 1'b1; alu_sel = ALU_PASS_A; end
          OP_OUT:   begin bus2_en = 1'b1; alu_sel = ALU_PASS_A; out_en = 1'b1; end
          OP_ADDI:  begin bus1_en = 1'b1; alu_sel = ALU_ADD; accu_en = 1'b1; flags_en = 1'b1; end
          OP_ADDM:  begin ram_cs  = 1'b1; alu_sel = ALU_ADD; accu_en = 1'b1; flags_en = 1'b1; end
          OP_NANDI: begin bus1_en = 1'b1; alu_sel = ALU_NAND; accu_en = 1'b1; flags_en = 1'b1; end
          OP_NANDM: begin ram_cs  = 1'b1; alu_sel = ALU_NAND; accu_en = 1'b1; flags_en = 1'b1; end
          default:  ;
        endcase
      end

      default: state_d = S_HALT;
    endcase
  end

  assign bus.phase    = phase;
  assign bus.halted   = halted;
  assign bus.pc_en    = pc_en;
  assign bus.pc_load  = pc_load;
  assign bus.fetch_en = fetch_en;
  assign bus.accu_en  = accu_en;
  assign bus.flags_en = flags_en;
  assign bus.bus1_en  = bus1_en;
  assign bus.bus2_en  = bus2_en;
  assign bus.in_en    = in_en;
  assign bus.out_en   = out_en;
  assign bus.ram_cs   = ram_cs;
  assign bus.ram_we   = ram_we;
  assign bus.alu_sel  = alu_sel;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_up_sequencer.sv
// Directed self-checking bench for up_sequencer.
// Control vector layout: {phase, halted, pc_en, pc_load, fetch_en, accu_en,
// flags_en, bus1_en, bus2_en, in_en, out_en, ram_cs, ram_we, alu_sel[2:0]}.
module tb_up_sequencer;

  localparam int unsigned RET_W = 8;

  localparam logic [15:0] C_HALT  = 16'h4000;
  localparam logic [15:0] C_FETCH = 16'h2800;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  up_sequencer_if #(.RET_W(RET_W)) bus ();

  up_sequencer #(.RET_W(RET_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] ctrl;
  assign ctrl = {bus.phase, bus.halted, bus.pc_en, bus.pc_load, bus.fetch_en,
                 bus.accu_en, bus.flags_en, bus.bus1_en, bus.bus2_en, bus.in_en,
                 bus.out_en, bus.ram_cs, bus.ram_we, bus.alu_sel};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-written expected EXEC control vectors
  function automatic logic [15:0] exp_exec(input int op, input logic c, input logic z);
    case (op)
      0:  return c  ? 16'h9000 : 16'hA000;
      1:  return !c ? 16'h9000 : 16'hA000;
      2:  return 16'h8301;
      3:  return 16'h8211;
      4:  return 16'h8502;
      5:  return 16'h8442;
      6:  return 16'h8412;
      7:  return 16'h8098;
      8:  return 16'h8703;
      9:  return 16'h8613;
      10: return 16'h9000;
      11: return 16'h80A0;
      12: return 16'h8704;
      13: return 16'h8614;
      14: return z  ? 16'h9000 : 16'hA000;
      15: return !z ? 16'h9000 : 16'hA000;
      default: return 16'h0000;
    endcase
  endfunction

  initial begin
    int drivers;
    reset      = 1'b0;
    bus.run    = 1'b0;
    bus.step   = 1'b0;
    bus.instr  = 4'b0000;
    bus.c_flag = 1'b0;
    bus.z_flag = 1'b0;

    // Reset state
    #3;
    chk("reset_ctrl", ctrl, C_HALT);
    chk("reset_retired", 16'(bus.retired), 16'd0);
    #4 reset = 1'b1;
    tick();
    chk("halt_idle", ctrl, C_HALT);

    // Free run of ADDI, phase alternates
    bus.run   = 1'b1;
    bus.instr = 4'b1000;
    tick(); chk("addi_fetch0", ctrl, C_FETCH);
    tick(); chk("addi_exec0", ctrl, 16'h8703);
    tick(); chk("addi_fetch1", ctrl, C_FETCH);
    chk("addi_retired1", 16'(bus.retired), 16'd1);
    tick(); chk("addi_exec1", ctrl, 16'h8703);

    // Asynchronous reset mid-EXEC
    #2 reset = 1'b0;
    #1;
    chk("midexec_reset_ctrl", ctrl, C_HALT);
    chk("midexec_reset_retired", 16'(bus.retired), 16'd0);
    #2 reset = 1'b1;
    tick(); chk("post_reset_fetch", ctrl, C_FETCH);

    // All opcodes x flag combinations while free-running
    for (int op = 0; op < 16; op++) begin
      for (int f = 0; f < 4; f++) begin
        chk("sweep_fetch", ctrl, C_FETCH);
        bus.instr  = 4'(op);
        bus.c_flag = f[0];
        bus.z_flag = f[1];
        tick();
        chk($sformatf("exec_op%0d_f%0d", op, f), ctrl, exp_exec(op, f[0], f[1]));
        drivers = int'(bus.bus1_en) + int'(bus.bus2_en) + int'(bus.in_en)
                + int'(bus.ram_cs & !bus.ram_we);
        chk("bus_exclusive", 16'(drivers <= 1), 16'd1);
        chk("ram_we_only_st", 16'(bus.ram_we), 16'(op == 7));
        tick();
      end
    end
    chk("sweep_retired", 16'(bus.retired), 16'd64);

    // Run to counter wrap; step pulses while running are ignored
    bus.instr = 4'b0100;
    for (int i = 0; i < 192; i++) begin
      if (i % 37 == 0) bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      if (i % 41 == 0) bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
    end
    chk("wrap_fetch", ctrl, C_FETCH);
    chk("wrap_retired0", 16'(bus.retired), 16'd0);
    tick(); tick();
    chk("wrap_retired1", 16'(bus.retired), 16'd1);

    // run falls during FETCH: instruction completes, then HALT
    bus.run = 1'b0;
    tick(); chk("runfall_exec", ctrl, 16'h8502);
    tick(); chk("runfall_halt", ctrl, C_HALT);
    chk("runfall_retired", 16'(bus.retired), 16'd2);
    tick(); chk("halt_stays", ctrl, C_HALT);

    // Single step: FETCH, EXEC, HALT, twice
    for (int s = 0; s < 2; s++) begin
      bus.step = 1'b1;
      tick(); bus.step = 1'b0;
      chk("step_fetch", ctrl, C_FETCH);
      tick(); chk("step_exec", ctrl, 16'h8502);
      tick(); chk("step_halt", ctrl, C_HALT);
      chk("step_retired", 16'(bus.retired), 16'(3 + s));
      tick(); chk("step_halt_hold", ctrl, C_HALT);
    end

    // step and run together in HALT: run wins, keeps running
    bus.run  = 1'b1;
    bus.step = 1'b1;
    tick(); bus.step = 1'b0;
    chk("runstep_fetch", ctrl, C_FETCH);
    tick(); chk("runstep_exec", ctrl, 16'h8502);
    tick(); chk("runstep_fetch2", ctrl, C_FETCH);
    bus.run = 1'b0;
    tick(); tick();
    chk("final_halt", ctrl, C_HALT);
    chk("final_retired", 16'(bus.retired), 16'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
